// File: rtl/flopen_write_arbiter_if.sv
// Write-request bundle between four requesters and the shared-register arbiter.
// The arbiter takes the slave side.
interface flopen_write_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [3:0]       grant;
    logic             E;
    logic [WIDTH-1:0] D;
    logic [3:0]       ack;
    logic             busy;
    logic [7:0]       wr_count;

    modport master (
        output req, d0, d1, d2, d3,
        input  grant, E, D, ack, busy, wr_count
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output grant, E, D, ack, busy, wr_count
    );
endinterface

// File: rtl/flopen_write_arbiter.sv
// Round-robin arbiter: one 3-cycle write transaction at a time
// into a shared enabled register.
module flopen_write_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    flopen_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_ACK
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_grant;
    logic [3:0] w_grant_next;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_next;
    logic       r_busy;
    logic [7:0] r_wr_count;

    logic [1:0]       w_win;
    logic             w_any;
    logic [1:0]       w_own;
    logic [WIDTH-1:0] w_wdata;
    logic             w_e;

    // Scan from farthest to nearest so the index closest to ptr wins.
    always_comb begin
        logic [1:0] w_idx;
        w_win = r_ptr;
        w_any = 1'b0;
        w_idx = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (bus.req[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_own = 2'd0;
        case (1'b1)
            r_grant[1]: w_own = 2'd1;
            r_grant[2]: w_own = 2'd2;
            r_grant[3]: w_own = 2'd3;
            default:    w_own = 2'd0;
        endcase
    end

    always_comb begin
        w_wdata = bus.d0;
        case (w_own)
            2'd1:    w_wdata = bus.d1;
            2'd2:    w_wdata = bus.d2;
            2'd3:    w_wdata = bus.d3;
            default: w_wdata = bus.d0;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_grant_next = r_grant;
        w_ptr_next   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next       = S_WRITE;
                    w_grant_next = 4'b0001 << w_win;
                    w_ptr_next   = w_win + 2'd1;
                end
            end
            S_WRITE: w_next = S_ACK;
            S_ACK: begin
                w_next       = S_IDLE;
                w_grant_next = 4'b0000;
            end
            default: begin
                w_next       = S_IDLE;
                w_grant_next = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 4'b0000;
            r_ptr      <= 2'd0;
            r_busy     <= 1'b0;
            r_wr_count <= 8'd0;
        end else begin
            r_state <= w_next;
            r_grant <= w_grant_next;
            r_ptr   <= w_ptr_next;
            r_busy  <= (w_next != S_IDLE);
            if (r_state == S_ACK) begin
                r_wr_count <= r_wr_count + 8'd1;
            end
        end
    end

    // Enable is masked by reset so a reset cycle never writes the register.
    assign w_e          = (r_state == S_WRITE) && reset;
    assign bus.E        = w_e;
    assign bus.D        = w_e ? w_wdata : '0;
    assign bus.ack      = (r_state == S_ACK) ? r_grant : 4'b0000;
    assign bus.grant    = r_grant;
    assign bus.busy     = r_busy;
    assign bus.wr_count = r_wr_count;
endmodule

// File: tb/tb_flopen_write_arbiter.sv
// Bench for flopen_write_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level model.
module tb_flopen_write_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    flopen_write_arbiter_if #(.WIDTH(32)) bus();

    flopen_write_arbiter #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // The shared Flopenr_32 register.
    logic [31:0] q;
    always @(posedge clk) if (bus.E) q <= bus.D;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 write, 2 ack.
    int          m_phase;
    int          m_own;
    int          m_ptr;
    int          m_cnt;
    logic [31:0] m_q;
    bit          m_qv = 0;

    function automatic logic [31:0] dsel(input int i);
        case (i)
            0:       return bus.d0;
            1:       return bus.d1;
            2:       return bus.d2;
            default: return bus.d3;
        endcase
    endfunction

    task automatic model_check();
        logic [3:0]  eg;
        logic        ee;
        logic [31:0] ed;
        logic [3:0]  ea;
        eg = (m_phase != 0) ? 4'(1 << m_own) : 4'b0000;
        ee = (m_phase == 1) && reset;
        ed = ee ? dsel(m_own) : 32'd0;
        ea = (m_phase == 2) ? 4'(1 << m_own) : 4'b0000;
        chk("m_grant", {28'd0, bus.grant}, {28'd0, eg});
        chk("m_E", {31'd0, bus.E}, {31'd0, ee});
        chk("m_D", bus.D, ed);
        chk("m_ack", {28'd0, bus.ack}, {28'd0, ea});
        chk("m_busy", {31'd0, bus.busy}, {31'd0, (m_phase != 0)});
        chk("m_cnt", {24'd0, bus.wr_count}, 32'(m_cnt));
        chk("m_ack_onehot", {31'd0, $onehot0(bus.ack)}, 32'd1);
        if (m_qv) chk("m_q", q, m_q);
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] rq);
        if (!rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_phase == 0) begin
            for (int k = 3; k >= 0; k--)
                if (rq[(m_ptr + k) % 4]) m_own = (m_ptr + k) % 4;
            if (rq != 0) begin
                m_ptr   = (m_own + 1) % 4;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_q     = dsel(m_own);
            m_qv    = 1;
            m_phase = 2;
        end else begin
            m_cnt   = (m_cnt + 1) % 256;
            m_phase = 0;
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] rq);
        reset   = rst;
        bus.req = rq;
        #2;
        model_check();
        @(posedge clk);
        model_edge(rst, rq);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  g;
        logic        e;
        logic [31:0] d;
        logic [3:0]  a;
        logic        b;
        logic [7:0]  c;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] seen[$];
    logic [31:0] exp_rr[5];

    initial begin
        tbl[0] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 32'd0,  4'b0000, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 32'd0,  4'b0000, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 4'b0000, 4'b0001, 1'b1, 32'd10, 4'b0000, 1'b1, 8'd0};
        tbl[3] = '{1'b1, 4'b0000, 4'b0001, 1'b0, 32'd0,  4'b0001, 1'b1, 8'd0};
        tbl[4] = '{1'b1, 4'b0100, 4'b0000, 1'b0, 32'd0,  4'b0000, 1'b0, 8'd1};
        tbl[5] = '{1'b1, 4'b0000, 4'b0100, 1'b1, 32'd94, 4'b0000, 1'b1, 8'd1};
        tbl[6] = '{1'b1, 4'b0000, 4'b0100, 1'b0, 32'd0,  4'b0100, 1'b1, 8'd1};
        tbl[7] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 32'd0,  4'b0000, 1'b0, 8'd2};

        reset   = 1'b0;
        bus.req = 4'b1111;
        bus.d0  = 32'd10;
        bus.d1  = 32'd11;
        bus.d2  = 32'd94;
        bus.d3  = 32'd13;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_phase = 0;
        m_ptr   = 0;
        m_cnt   = 0;

        foreach (tbl[i]) begin
            reset   = tbl[i].rst;
            bus.req = tbl[i].req;
            #2;
            chk($sformatf("t%0d_grant", i), {28'd0, bus.grant}, {28'd0, tbl[i].g});
            chk($sformatf("t%0d_E", i), {31'd0, bus.E}, {31'd0, tbl[i].e});
            chk($sformatf("t%0d_D", i), bus.D, tbl[i].d);
            chk($sformatf("t%0d_ack", i), {28'd0, bus.ack}, {28'd0, tbl[i].a});
            chk($sformatf("t%0d_busy", i), {31'd0, bus.busy}, {31'd0, tbl[i].b});
            chk($sformatf("t%0d_cnt", i), {24'd0, bus.wr_count}, {24'd0, tbl[i].c});
            model_check();
            @(posedge clk);
            model_edge(tbl[i].rst, tbl[i].req);
            #1;
        end
        chk("single_q", q, 32'd94);

        // Fairness with all four requesting.
        do_reset();
        bus.d2 = 32'd12;
        exp_rr = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd10};
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 4'b1111);
            if (bus.ack != 4'b0000) seen.push_back(q);
        end
        chk("rr_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5 && i < seen.size(); i++)
            chk($sformatf("rr_q%0d", i), seen[i], exp_rr[i]);

        // Priority rotation: ptr lands on 2 after granting 1.
        do_reset();
        step(1'b1, 4'b0010);
        step(1'b1, 4'b0000);
        chk("rot_ack1", {28'd0, bus.ack}, 32'h2);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0011);
        chk("rot_grant0", {28'd0, bus.grant}, 32'h1);
        step(1'b1, 4'b0011);
        chk("rot_ack0", {28'd0, bus.ack}, 32'h1);
        step(1'b1, 4'b0010);
        step(1'b1, 4'b0010);
        chk("rot_grant1", {28'd0, bus.grant}, 32'h2);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);

        // Reset arriving during WRITE.
        do_reset();
        bus.d2 = 32'd94;
        bus.d1 = 32'd55;
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0010);
        reset   = 1'b0;
        bus.req = 4'b0000;
        #2;
        chk("mid_E", {31'd0, bus.E}, 32'd0);
        model_check();
        @(posedge clk);
        model_edge(1'b0, 4'b0000);
        #1;
        chk("mid_q", q, 32'd94);
        chk("mid_ack", {28'd0, bus.ack}, 32'd0);
        chk("mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_cnt", {24'd0, bus.wr_count}, 32'd0);
        step(1'b1, 4'b0000);
        chk("mid_ack2", {28'd0, bus.ack}, 32'd0);

        // Counter wrap with a held request from requester 3.
        do_reset();
        bus.d3 = 32'hA5;
        for (int i = 0; i < 765; i++) step(1'b1, 4'b1000);
        chk("wrap_255", {24'd0, bus.wr_count}, 32'd255);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1000);
        chk("wrap_0", {24'd0, bus.wr_count}, 32'd0);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.d0 = $urandom;
            bus.d1 = $urandom;
            bus.d2 = $urandom;
            bus.d3 = $urandom;
            step(($urandom_range(0, 29) != 0), 4'($urandom_range(0, 15)));
        end
        step(1'b1, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
